iob_integ: RTL and testbench

- Streaming integrator, the inverse of the team's first-difference block: accumulates a stream of signed deltas and reconstructs the original sample stream.
- Sits on the receive/decode side of delta-coded data paths, e.g. behind a UART/DMA stream carrying differences.
- Valid/ready on both sides; registered output; 1-cycle latency.

---
 rtl/iob_integ_pkg.sv | 15 +
 rtl/iob_integ_if.sv | 23 ++
 rtl/iob_integ_add.sv | 40 ++++
 rtl/iob_integ.sv | 70 +++++++
 tb/tb_iob_integ.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/iob_integ_pkg.sv
// iob_integ shared constants for the streaming integrator.
// Build option: IOB_INTEG_SAT_EN selects saturating accumulation.
package iob_integ_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 32;

  localparam int EXT_W = DEF_ACC_W - DEF_DATA_W;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX =
    {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] ACC_MIN =
    {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/iob_integ_if.sv
// iob_integ valid/ready stream bundle.
// Build option: none (IOB_INTEG_SAT_EN lives in iob_integ_add).
interface iob_integ_if #(
  parameter int W = 32
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/iob_integ_add.sv
// iob_integ signed accumulate step with overflow detect.
// Build option: IOB_INTEG_SAT_EN clamps instead of wrapping.
module iob_integ_add
  import iob_integ_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] delta,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] MAX_V =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;

  always_comb begin
    ext = ACC_W'(signed'(delta));
    raw = acc + ext;
    // equal operand signs with a flipped result sign
    ovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
          (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef IOB_INTEG_SAT_EN
    if (ovf) begin
      sum = acc[ACC_W-1] ? MIN_V : MAX_V;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/iob_integ.sv
// iob_integ streaming integrator: rebuilds samples from deltas.
// Build option: IOB_INTEG_SAT_EN (see iob_integ_add).
module iob_integ
  import iob_integ_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter int               ACC_W   = DEF_ACC_W,
  parameter logic [ACC_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_val_i,
  iob_integ_if.slave       in_s,
  iob_integ_if.master      out_m,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             valid;
  logic             ovf;
  logic             ready;
  logic             in_fire;
  logic             out_fire;

  iob_integ_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc),
    .delta (in_s.data),
    .sum   (sum),
    .ovf   (add_ovf)
  );

  assign ready    = (~valid | out_m.ready) & ~load_i;
  assign in_fire  = in_s.valid & ready;
  assign out_fire = valid & out_m.ready;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        acc   <= RST_VAL;
        valid <= 1'b0;
        ovf   <= 1'b0;
      end else if (load_i) begin
        acc <= load_val_i;
        ovf <= 1'b0;
        if (out_fire) begin
          valid <= 1'b0;
        end
      end else if (in_fire) begin
        acc   <= sum;
        valid <= 1'b1;
        ovf   <= ovf | add_ovf;
      end else if (out_fire) begin
        valid <= 1'b0;
      end
    end
  end

  assign in_s.ready  = ready;
  assign out_m.valid = valid;
  assign out_m.data  = acc;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_iob_integ.sv
// Directed vector bench for iob_integ (DATA_W=8, ACC_W=16).
// Expected overflow values follow IOB_INTEG_SAT_EN.
module tb_iob_integ;

`ifdef IOB_INTEG_SAT_EN
  localparam logic [15:0] E_POS1 = 16'h7FFF;
  localparam logic [15:0] E_POS2 = 16'h7FFE;
  localparam logic [15:0] E_NEG1 = 16'h8000;
  localparam logic [15:0] E_NEG2 = 16'h8001;
  localparam logic [15:0] E_NEG3 = 16'h8004;
`else
  localparam logic [15:0] E_POS1 = 16'h8002;
  localparam logic [15:0] E_POS2 = 16'h8001;
  localparam logic [15:0] E_NEG1 = 16'h7FC4;
  localparam logic [15:0] E_NEG2 = 16'h7FC5;
  localparam logic [15:0] E_NEG3 = 16'h7FC8;
`endif

  logic        clk = 1'b0;
  logic        cke;
  logic        rst_n;
  logic        load;
  logic [15:0] load_val;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  iob_integ_if #(.W(8))  in_if ();
  iob_integ_if #(.W(16)) out_if ();

  iob_integ #(
    .DATA_W  (8),
    .ACC_W   (16),
    .RST_VAL (16'd0)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .rst_n_i    (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .in_s       (in_if),
    .out_m      (out_if),
    .ovf_o      (ovf)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ri;
    logic        ld;
    logic [15:0] lv;
    logic        er;
    logic        ev;
    logic [15:0] ed;
    logic        eo;
  } vec_t;

  localparam int N = 26;
  vec_t vt [N];

  function automatic vec_t mk(
    logic v, logic [7:0] d, logic ri, logic ld,
    logic [15:0] lv, logic er, logic ev,
    logic [15:0] ed, logic eo);
    vec_t r;
    r.v = v; r.d = d; r.ri = ri; r.ld = ld; r.lv = lv;
    r.er = er; r.ev = ev; r.ed = ed; r.eo = eo;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d,
                       logic ri, logic ld,
                       logic [15:0] lv);
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = ri;
    load         = ld;
    load_val     = lv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stream 5,-3,10 then drain
    vt[0]  = mk(1, 8'd5,   1, 0, 0, 1, 1, 16'd5,  0);
    vt[1]  = mk(1, 8'hFD,  1, 0, 0, 1, 1, 16'd2,  0);
    vt[2]  = mk(1, 8'd10,  1, 0, 0, 1, 1, 16'd12, 0);
    vt[3]  = mk(0, 8'd0,   1, 0, 0, 1, 0, 16'd12, 0);
    // round trip of samples 7,7,100,0
    vt[4]  = mk(0, 8'd0,   1, 1, 0, 0, 0, 16'd0,  0);
    vt[5]  = mk(1, 8'd7,   1, 0, 0, 1, 1, 16'd7,  0);
    vt[6]  = mk(1, 8'd0,   1, 0, 0, 1, 1, 16'd7,  0);
    vt[7]  = mk(1, 8'd93,  1, 0, 0, 1, 1, 16'd100, 0);
    vt[8]  = mk(1, 8'h9C,  1, 0, 0, 1, 1, 16'd0,  0);
    vt[9]  = mk(0, 8'd0,   1, 0, 0, 1, 0, 16'd0,  0);
    // backpressure
    vt[10] = mk(1, 8'd4,   0, 0, 0, 1, 1, 16'd4,  0);
    vt[11] = mk(1, 8'd1,   0, 0, 0, 0, 1, 16'd4,  0);
    vt[12] = mk(1, 8'd1,   0, 0, 0, 0, 1, 16'd4,  0);
    vt[13] = mk(1, 8'd1,   1, 0, 0, 1, 1, 16'd5,  0);
    vt[14] = mk(0, 8'd0,   1, 0, 0, 1, 0, 16'd5,  0);
    // load beats delta
    vt[15] = mk(1, 8'd9,   1, 1, 16'd1000, 0, 0, 16'd1000, 0);
    vt[16] = mk(1, 8'd9,   1, 0, 0, 1, 1, 16'd1009, 0);
    vt[17] = mk(0, 8'd0,   1, 0, 0, 1, 0, 16'd1009, 0);
    // positive overflow
    vt[18] = mk(0, 8'd0,   1, 1, 16'd32760, 0, 0, 16'd32760, 0);
    vt[19] = mk(1, 8'd10,  1, 0, 0, 1, 1, E_POS1, 1);
    vt[20] = mk(1, 8'hFF,  1, 0, 0, 1, 1, E_POS2, 1);
    vt[21] = mk(0, 8'd0,   1, 0, 0, 1, 0, E_POS2, 1);
    // negative overflow, load clears ovf
    vt[22] = mk(0, 8'd0,   1, 1, 16'h8044, 0, 0, 16'h8044, 0);
    vt[23] = mk(1, 8'h80,  1, 0, 0, 1, 1, E_NEG1, 1);
    vt[24] = mk(1, 8'd1,   1, 0, 0, 1, 1, E_NEG2, 1);
    vt[25] = mk(0, 8'd0,   1, 0, 0, 1, 0, E_NEG2, 1);

    cke   = 1'b1;
    rst_n = 1'b0;
    drive(0, 8'd0, 1, 0, 16'd0);
    tick();
    tick();
    chk("rst valid", out_if.valid, 0);
    chk("rst data", out_if.data, 16'd0);
    chk("rst ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst ready", in_if.ready, 1);

    for (int i = 0; i < N; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].ri, vt[i].ld, vt[i].lv);
      #1;
      chk($sformatf("v%0d ready", i), in_if.ready, vt[i].er);
      tick();
      chk($sformatf("v%0d valid", i), out_if.valid, vt[i].ev);
      chk($sformatf("v%0d data", i), out_if.data, vt[i].ed);
      chk($sformatf("v%0d ovf", i), ovf, vt[i].eo);
    end

    // reset while an output is held
    drive(1, 8'd3, 0, 0, 16'd0);
    tick();
    chk("held valid", out_if.valid, 1);
    chk("held data", out_if.data, E_NEG3);
    rst_n = 1'b0;
    tick();
    chk("midrst valid", out_if.valid, 0);
    chk("midrst data", out_if.data, 16'd0);
    chk("midrst ovf", ovf, 0);
    rst_n = 1'b1;

    drive(1, 8'd6, 0, 0, 16'd0);
    tick();
    chk("pre cke valid", out_if.valid, 1);
    chk("pre cke data", out_if.data, 16'd6);

    // clock enable low freezes everything, even load and reset
    cke = 1'b0;
    drive(1, 8'd1, 0, 0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        load     = 1'b1;
        load_val = 16'd77;
      end
      if (k == 2) begin
        load  = 1'b0;
        rst_n = 1'b0;
      end
      tick();
      chk($sformatf("cke%0d valid", k), out_if.valid, 1);
      chk($sformatf("cke%0d data", k), out_if.data, 16'd6);
      chk($sformatf("cke%0d ready", k), in_if.ready, 0);
    end

    cke   = 1'b1;
    rst_n = 1'b1;
    drive(0, 8'd0, 1, 0, 16'd0);
    #1;
    chk("post cke ready", in_if.ready, 1);
    tick();
    chk("post cke valid", out_if.valid, 0);
    chk("post cke data", out_if.data, 16'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
